// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the seven-segment scan/load controller.
package seg_scan_ctrl_pkg;

    // Controller states: SCAN multiplexes the display, LOAD strobes the digit registers.
    typedef enum logic {
        SCAN = 1'b0,
        LOAD = 1'b1
    } state_e;

    // Width of the digit index / register select.
    localparam int SEL_W = 3;

    // All segments off (active-low segment drive).
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Pattern the digit registers hold out of reset.
    localparam logic [6:0] SEG_RESET = 7'b0000001;

    // Increment an index, wrapping from 'last' back to zero.
    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] v,
                                                  input int unsigned      last);
        if (v == SEL_W'(last)) begin
            return '0;
        end
        return v + SEL_W'(1);
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_refresh_tick.sv
// Free-running refresh divider: one-cycle tick every REFRESH_DIV clocks.
module seg_refresh_tick
    import seg_scan_ctrl_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int              CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Tick on the terminal count; the counter wraps on the same edge.
    assign tick = (cnt_q == CNT_LAST);

    // Next count: wrap to zero after the terminal value.
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Seven-segment controller: after each multiplier result it walks the digit
// register select with a load strobe, otherwise it time-multiplexes the
// captured digit patterns onto a shared segment bus with active-low anodes.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS  = 5,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mul_done,
    input  logic [7*NUM_DIGITS-1:0] seg_data_in,
    output logic [SEL_W-1:0]        seg_mux_sel,
    output logic                    done,
    output logic                    busy,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg_out
);

    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_DIGITS - 1);

    state_e                  state_q, state_d;
    logic                    pending_q, pending_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic                    done_q, done_d;
    logic [SEL_W-1:0]        scan_idx_q, scan_idx_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;

    logic                    tick;
    logic [NUM_DIGITS-1:0]   scan_an;
    logic [6:0]              scan_seg;

    seg_refresh_tick #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_refresh (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Scan index advances on every refresh tick, independent of LOAD.
    always_comb begin
        scan_idx_d = tick ? wrap_inc(scan_idx_q, NUM_DIGITS - 1) : scan_idx_q;
    end

    // Select the anode and segment slice for the current scan index.
    always_comb begin
        scan_an  = '1;
        scan_seg = SEG_BLANK;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (scan_idx_q == SEL_W'(k)) begin
                scan_an[k] = 1'b0;
                scan_seg   = seg_data_in[7*k +: 7];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SCAN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a result (or a queued one) starts LOAD; LOAD ends after the last digit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SCAN: begin
                if (mul_done || pending_q) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (sel_q == LAST_SEL) begin
                    state_d = SCAN;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    // FSM outputs: strobe/select sequencing, pending capture and blanked display in LOAD.
    always_comb begin
        sel_d     = sel_q;
        done_d    = 1'b0;
        pending_d = pending_q;
        an_d      = scan_an;
        seg_d     = scan_seg;

        // Outputs are registered, so they are derived from the state being entered.
        if (state_d == LOAD) begin
            done_d = 1'b1;
            an_d   = '1;
            seg_d  = SEG_BLANK;
        end

        case (state_q)
            SCAN: begin
                if (state_d == LOAD) begin
                    sel_d     = '0;
                    pending_d = 1'b0;
                end
            end
            LOAD: begin
                // Any number of results during LOAD collapse into one reload.
                pending_d = pending_q | mul_done;
                if (state_d == LOAD) begin
                    sel_d = sel_q + SEL_W'(1);
                end
            end
            default: begin
                sel_d     = '0;
                pending_d = 1'b0;
            end
        endcase
    end

    // Control and display registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q  <= 1'b0;
            sel_q      <= '0;
            done_q     <= 1'b0;
            scan_idx_q <= '0;
            an_q       <= '1;
            seg_q      <= SEG_BLANK;
        end else begin
            pending_q  <= pending_d;
            sel_q      <= sel_d;
            done_q     <= done_d;
            scan_idx_q <= scan_idx_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
        end
    end

    assign seg_mux_sel = sel_q;
    assign done        = done_q;
    assign busy        = (state_q == LOAD);
    assign an          = an_q;
    assign seg_out     = seg_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed testbench for seg_scan_ctrl with a behavioural model of the digit registers.
module tb_seg_scan_ctrl;
    import seg_scan_ctrl_pkg::*;

    localparam int ND = 5;
    localparam int RD = 4;

    logic          clk;
    logic          rst;
    logic          mul_done;
    logic [7*ND-1:0] seg_data_in;
    logic [2:0]    seg_mux_sel;
    logic          done;
    logic          busy;
    logic [ND-1:0] an;
    logic [6:0]    seg_out;

    logic [6:0] digit_q [ND];
    logic [6:0] dec_pat [ND];

    int n_chk;
    int n_fail;
    int cyc;

    seg_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mul_done    (mul_done),
        .seg_data_in (seg_data_in),
        .seg_mux_sel (seg_mux_sel),
        .done        (done),
        .busy        (busy),
        .an          (an),
        .seg_out     (seg_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clock edges since reset release.
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    // Digit registers: capture the decoder pattern of the selected digit on each strobe.
    always @(posedge clk) begin
        if (done && seg_mux_sel < 3'd5) digit_q[seg_mux_sel] <= dec_pat[seg_mux_sel];
    end

    always_comb begin
        seg_data_in = '0;
        for (int k = 0; k < ND; k++) seg_data_in[7*k +: 7] = digit_q[k];
    end

    // Expected anode pattern n edges after reset release (one-cycle latency from scan index).
    function automatic logic [ND-1:0] exp_an(input int n);
        int idx;
        idx = ((n - 1) / RD) % ND;
        return ~(5'b00001 << idx);
    endfunction

    // Invariants checked every cycle.
    always @(negedge clk) begin
        n_chk = n_chk + 3;
        if ($countones(~an) > 1) begin
            n_fail++; $display("FAIL an_onehot0 an=%b", an);
        end
        if (done && !busy) begin
            n_fail++; $display("FAIL done_implies_busy done=%b busy=%b", done, busy);
        end
        if (seg_mux_sel > 3'd4) begin
            n_fail++; $display("FAIL sel_range sel=%0d max=4", seg_mux_sel);
        end
    end

    task automatic test_reset();
        rst = 1'b0;
        mul_done = 1'b0;
        repeat (3) @(negedge clk);
        n_chk = n_chk + 5;
        if (an !== 5'b11111) begin n_fail++; $display("FAIL reset_an got=%b exp=11111", an); end
        if (seg_out !== SEG_BLANK) begin n_fail++; $display("FAIL reset_seg got=%b exp=%b", seg_out, SEG_BLANK); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (seg_mux_sel !== 3'd0) begin n_fail++; $display("FAIL reset_sel got=%0d exp=0", seg_mux_sel); end
        rst = 1'b1;
    endtask

    task automatic test_scan();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n_chk = n_chk + 3;
            if (an !== exp_an(cyc)) begin n_fail++; $display("FAIL scan_an cyc=%0d got=%b exp=%b", cyc, an, exp_an(cyc)); end
            if (seg_out !== SEG_RESET) begin n_fail++; $display("FAIL scan_seg cyc=%0d got=%b exp=%b", cyc, seg_out, SEG_RESET); end
            if (done !== 1'b0) begin n_fail++; $display("FAIL scan_done cyc=%0d got=%b exp=0", cyc, done); end
        end
    endtask

    task automatic test_single_load();
        @(negedge clk); mul_done = 1'b1;
        @(negedge clk); mul_done = 1'b0;
        for (int k = 0; k < ND; k++) begin
            n_chk = n_chk + 4;
            if (done !== 1'b1) begin n_fail++; $display("FAIL load_done k=%0d got=%b exp=1", k, done); end
            if (busy !== 1'b1) begin n_fail++; $display("FAIL load_busy k=%0d got=%b exp=1", k, busy); end
            if (seg_mux_sel !== 3'(k)) begin n_fail++; $display("FAIL load_sel got=%0d exp=%0d", seg_mux_sel, k); end
            if (an !== 5'b11111) begin n_fail++; $display("FAIL load_an k=%0d got=%b exp=11111", k, an); end
            @(negedge clk);
        end
        n_chk = n_chk + 4;
        if (done !== 1'b0) begin n_fail++; $display("FAIL end_done got=%b exp=0", done); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL end_busy got=%b exp=0", busy); end
        if (seg_mux_sel !== 3'd4) begin n_fail++; $display("FAIL end_sel got=%0d exp=4", seg_mux_sel); end
        if (an !== exp_an(cyc)) begin n_fail++; $display("FAIL end_an got=%b exp=%b", an, exp_an(cyc)); end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_chk = n_chk + 2;
            if (an !== exp_an(cyc)) begin n_fail++; $display("FAIL resume_an cyc=%0d got=%b exp=%b", cyc, an, exp_an(cyc)); end
            if (busy !== 1'b0) begin n_fail++; $display("FAIL resume_busy got=%b exp=0", busy); end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk); mul_done = 1'b1;
        @(negedge clk);
        for (int k = 0; k < ND; k++) begin
            mul_done = (k == 2 || k == 4);
            n_chk = n_chk + 3;
            if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done1 k=%0d got=%b exp=1", k, done); end
            if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy1 k=%0d got=%b exp=1", k, busy); end
            if (seg_mux_sel !== 3'(k)) begin n_fail++; $display("FAIL b2b_sel1 got=%0d exp=%0d", seg_mux_sel, k); end
            @(negedge clk);
        end
        mul_done = 1'b0;
        n_chk = n_chk + 4;
        if (done !== 1'b0) begin n_fail++; $display("FAIL gap_done got=%b exp=0", done); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL gap_busy got=%b exp=0", busy); end
        if (seg_mux_sel !== 3'd4) begin n_fail++; $display("FAIL gap_sel got=%0d exp=4", seg_mux_sel); end
        if (an !== exp_an(cyc)) begin n_fail++; $display("FAIL gap_an got=%b exp=%b", an, exp_an(cyc)); end
        @(negedge clk);
        for (int k = 0; k < ND; k++) begin
            n_chk = n_chk + 3;
            if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done2 k=%0d got=%b exp=1", k, done); end
            if (seg_mux_sel !== 3'(k)) begin n_fail++; $display("FAIL b2b_sel2 got=%0d exp=%0d", seg_mux_sel, k); end
            if (an !== 5'b11111) begin n_fail++; $display("FAIL b2b_an2 k=%0d got=%b exp=11111", k, an); end
            @(negedge clk);
        end
        for (int i = 0; i < 10; i++) begin
            n_chk = n_chk + 2;
            if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_extra_busy i=%0d got=%b exp=0", i, busy); end
            if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_extra_done i=%0d got=%b exp=0", i, done); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_load();
        @(negedge clk); mul_done = 1'b1;
        @(negedge clk); mul_done = 1'b0;
        for (int k = 0; k < 3; k++) @(negedge clk);
        n_chk = n_chk + 1;
        if (seg_mux_sel !== 3'd3) begin n_fail++; $display("FAIL mid_sel got=%0d exp=3", seg_mux_sel); end
        #2 rst = 1'b0;
        #1;
        n_chk = n_chk + 4;
        if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done got=%b exp=0", done); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", busy); end
        if (seg_mux_sel !== 3'd0) begin n_fail++; $display("FAIL abort_sel got=%0d exp=0", seg_mux_sel); end
        if (an !== 5'b11111) begin n_fail++; $display("FAIL abort_an got=%b exp=11111", an); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_chk = n_chk + 3;
            if (busy !== 1'b0) begin n_fail++; $display("FAIL post_rst_busy cyc=%0d got=%b exp=0", cyc, busy); end
            if (done !== 1'b0) begin n_fail++; $display("FAIL post_rst_done cyc=%0d got=%b exp=0", cyc, done); end
            if (an !== exp_an(cyc)) begin n_fail++; $display("FAIL post_rst_an cyc=%0d got=%b exp=%b", cyc, an, exp_an(cyc)); end
        end
    endtask

    task automatic test_patterns();
        int t;
        int low;
        dec_pat[0] = 7'h40; dec_pat[1] = 7'h79; dec_pat[2] = 7'h24;
        dec_pat[3] = 7'h30; dec_pat[4] = 7'h19;
        @(negedge clk); mul_done = 1'b1;
        @(negedge clk); mul_done = 1'b0;
        t = 0;
        while (busy && t < 20) begin
            @(negedge clk);
            t++;
        end
        n_chk = n_chk + 1;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL pat_load_timeout busy=%b exp=0", busy); end
        // The first SCAN cycle may still show a slice sampled before the last digit was captured.
        @(negedge clk);
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            low = -1;
            for (int k = 0; k < ND; k++) if (an[k] == 1'b0) low = k;
            n_chk = n_chk + 2;
            if (an !== exp_an(cyc)) begin n_fail++; $display("FAIL pat_an cyc=%0d got=%b exp=%b", cyc, an, exp_an(cyc)); end
            if (low < 0) begin
                n_fail++; $display("FAIL pat_seg cyc=%0d no digit enabled an=%b", cyc, an);
            end else if (seg_out !== dec_pat[low]) begin
                n_fail++; $display("FAIL pat_seg digit=%0d got=%h exp=%h", low, seg_out, dec_pat[low]);
            end
        end
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        mul_done = 1'b0;
        rst = 1'b0;
        for (int k = 0; k < ND; k++) begin
            digit_q[k] = SEG_RESET;
            dec_pat[k] = SEG_RESET;
        end
        test_reset();
        test_scan();
        test_single_load();
        test_back_to_back();
        test_reset_mid_load();
        test_patterns();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Sequences the per-digit seven-segment capture registers after each multiplier result.
- On a result-done pulse it walks seg_mux_sel through 0..NUM_DIGITS-1 with a load strobe, so each digit register captures its decoded pattern.
- Otherwise it time-multiplexes the captured patterns onto one shared segment bus with active-low anode enables.

Parameters:
- NUM_DIGITS, 5, number of digit registers and anodes (legal 1..8).
- REFRESH_DIV, 50000, clk cycles per digit during scanning (legal >=2).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- mul_done  input  1  one-cycle pulse: new product valid at the digit decoders
- seg_data_in  input  7*NUM_DIGITS  captured digit patterns; digit k at bits [7k+6:7k]
- seg_mux_sel  output  3  digit index being loaded; drives digit-register select
- done  output  1  load strobe to digit registers; high once per digit index during LOAD
- busy  output  1  high while in LOAD
- an  output  NUM_DIGITS  anode enables, active-low, one-hot-zero
- seg_out  output  7  segment pattern for the enabled digit

Behaviour:
- Reset (rst=0, asynchronous):
  - state=SCAN, seg_mux_sel=0, done=0, busy=0, pending=0.
  - Refresh counter=0, scan_idx=0.
  - an=all ones, seg_out=7'b1111111.
- Reset mid-LOAD aborts the load. Digit registers keep whatever they captured; no completion is signalled.
- States:
  - SCAN (default).
  - LOAD.
- SCAN:
  - The refresh counter counts 0..REFRESH_DIV-1. A tick is produced on the terminal count, then the counter wraps to 0.
  - On a tick, scan_idx increments and wraps NUM_DIGITS-1 -> 0.
  - an and seg_out are registered, with 1-cycle latency from scan_idx.
  - an = ~(1<<scan_idx) and seg_out = seg_data_in slice[scan_idx].
- SCAN -> LOAD:
  - Taken on mul_done=1, or pending=1.
  - On the next edge: busy=1, done=1, seg_mux_sel=0; pending is cleared.
- LOAD:
  - Each cycle, done=1 and seg_mux_sel increments.
  - When seg_mux_sel==NUM_DIGITS-1 with done=1, the next edge returns to SCAN with done=0, busy=0, seg_mux_sel held at NUM_DIGITS-1.
  - LOAD therefore lasts exactly NUM_DIGITS cycles; digit k is strobed in LOAD cycle k.
  - an=all ones (blank) for the whole of LOAD. seg_out is don't-care but must not glitch an.
  - The refresh counter and scan_idx keep running through LOAD, so scan timing is unaffected.
- mul_done during LOAD sets pending=1. After LOAD ends, exactly one SCAN cycle elapses, then LOAD restarts from seg_mux_sel=0.
- Multiple mul_done pulses during one LOAD collapse into one pending reload.
- mul_done in the same cycle LOAD completes also sets pending.
- After LOAD returns to SCAN, an resumes on the next registered update with the current scan_idx.
- done is never high outside LOAD. seg_mux_sel never exceeds NUM_DIGITS-1.
- Refresh counter width is clog2(REFRESH_DIV). scan_idx width is 3 bits.

Decomposition:
- Shared package/include holds:
  - state encodings: SCAN=1'b0, LOAD=1'b1.
  - SEG_BLANK=7'b1111111.
  - SEG_RESET=7'b0000001, the digit-register reset pattern, used by the bench.
  - SEL_W=3.
- One sub-module: seg_refresh_tick. Parameter REFRESH_DIV; ports clk, rst, tick. It owns the refresh counter.
- FSM, pending flag, scan index and output registers stay in seg_scan_ctrl.

Test Plan:
Sim settings: NUM_DIGITS=5, REFRESH_DIV=4.
- Reset then run 40 cycles, digit registers at reset value 7'b0000001 -> an steps 11110, 11101, 11011, 10111, 01111 every 4 cycles with 1-cycle latency; seg_out=0000001 throughout; done stays 0.
- Single mul_done pulse -> next 5 cycles show done=1 with seg_mux_sel 0,1,2,3,4; busy=1 for those cycles; an=11111. Return to SCAN with done=0; scanning resumes with the correct scan_idx phase.
- mul_done at LOAD cycle 2, plus a second pulse at cycle 4 -> the first LOAD completes normally, one SCAN cycle follows, then exactly one more 5-cycle LOAD.
- rst low during LOAD cycle 3 -> done, busy and seg_mux_sel go to 0 and an to 11111 asynchronously, within the same cycle. After release: SCAN from scan_idx=0, and no LOAD without a new mul_done.
- Digit registers hold patterns 7'h40, 7'h79, 7'h24, 7'h30, 7'h19 after a LOAD -> seg_out shows each pattern in the same cycle that its an bit is low; no slice misalignment.
- Assertions throughout all scenarios:
  - an is one-hot-zero or all ones.
  - done implies busy.
  - seg_mux_sel <= 4.
